// File: rtl/fm_row_packer.sv
// Feature-map row packer: assembles a byte-serial pixel stream into packed rows,
// double-buffered, with row tags, end-of-frame marking and mid-frame SOF detection.
module fm_row_packer #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned ROW_PIX = 26
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic [PIX_W-1:0]         i_pix_data,
  input  logic                     i_pix_valid,
  input  logic                     i_sof,
  output logic                     o_pix_ready,
  output logic [PIX_W*ROW_PIX-1:0] o_parallel_data,
  output logic                     o_fm_data_valid,
  output logic [4:0]               o_row_idx,
  output logic                     o_frame_end,
  output logic                     o_sof_err
);

  localparam int unsigned RowW = PIX_W * ROW_PIX;
  localparam int unsigned IdxW = $clog2(RowW);
  localparam logic [4:0]  LastIdx = 5'(ROW_PIX - 1);

  logic [RowW-1:0] buf_data_q [2];
  logic [4:0]      buf_tag_q  [2];
  logic [1:0]      full_q;
  logic            wr_sel_q;
  logic            rd_sel_q;
  logic [4:0]      col_q;
  logic [4:0]      wr_row_q;

  logic            accept;
  logic            sof_mid;
  logic            rd_fire;
  logic [4:0]      eff_col;
  logic [4:0]      eff_row;
  logic [IdxW-1:0] wr_lsb;

  always_comb begin
    o_pix_ready = i_rst_n & ~full_q[wr_sel_q];
    accept      = i_pix_valid & o_pix_ready;
    // SOF anywhere but row 0 / col 0 restarts the frame in the current buffer
    sof_mid     = i_sof & ((col_q != '0) | (wr_row_q != '0));
    eff_col     = sof_mid ? '0 : col_q;
    eff_row     = sof_mid ? '0 : wr_row_q;
    wr_lsb      = IdxW'((LastIdx - eff_col) * PIX_W);
    rd_fire     = i_en & full_q[rd_sel_q];
  end

  // Row payload needs no reset: a buffer is only read after all columns are written.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      buf_data_q[wr_sel_q][wr_lsb +: PIX_W] <= i_pix_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      buf_tag_q[0]    <= '0;
      buf_tag_q[1]    <= '0;
      full_q          <= '0;
      wr_sel_q        <= 1'b0;
      rd_sel_q        <= 1'b0;
      col_q           <= '0;
      wr_row_q        <= '0;
      o_parallel_data <= '0;
      o_fm_data_valid <= 1'b0;
      o_row_idx       <= '0;
      o_frame_end     <= 1'b0;
      o_sof_err       <= 1'b0;
    end else begin
      o_fm_data_valid <= 1'b0;
      o_frame_end     <= 1'b0;

      if (accept) begin
        if (sof_mid) begin
          o_sof_err <= 1'b1;
        end
        if (eff_col == LastIdx) begin
          full_q[wr_sel_q]    <= 1'b1;
          buf_tag_q[wr_sel_q] <= eff_row;
          wr_sel_q            <= ~wr_sel_q;
          col_q               <= '0;
          wr_row_q            <= (eff_row == LastIdx) ? '0 : eff_row + 5'd1;
        end else begin
          col_q    <= eff_col + 5'd1;
          wr_row_q <= eff_row;
        end
      end

      // Read and write never target the same buffer: one needs it full, the other empty.
      if (rd_fire) begin
        o_parallel_data  <= buf_data_q[rd_sel_q];
        o_row_idx        <= buf_tag_q[rd_sel_q];
        o_fm_data_valid  <= 1'b1;
        o_frame_end      <= (buf_tag_q[rd_sel_q] == LastIdx);
        full_q[rd_sel_q] <= 1'b0;
        rd_sel_q         <= ~rd_sel_q;
      end
    end
  end

endmodule

// File: tb/tb_fm_row_packer.sv
// Scoreboard bench for fm_row_packer: a reference model queues expected rows on
// accepted pixels; a monitor pops and compares each emitted row.
module tb_fm_row_packer;

  localparam int FramePix = 676;

  typedef struct packed {
    logic [207:0] data;
    logic [4:0]   idx;
  } row_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         en_nx = 1'b0;
  logic [7:0]   pix_data = 8'h00;
  logic         pix_valid = 1'b0;
  logic         sof = 1'b0;
  logic         o_pix_ready;
  logic [207:0] o_parallel_data;
  logic         o_fm_data_valid;
  logic [4:0]   o_row_idx;
  logic         o_frame_end;
  logic         o_sof_err;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           fe_cnt = 0;
  int           pulse_cyc[$];
  int           row_end_edge[$];
  row_t         exp_q[$];
  row_t         mon_e;

  int           m_col = 0;
  int           m_row = 0;
  logic [207:0] m_data = '0;

  fm_row_packer #(
    .PIX_W  (8),
    .ROW_PIX(26)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_en           (en),
    .i_pix_data     (pix_data),
    .i_pix_valid    (pix_valid),
    .i_sof          (sof),
    .o_pix_ready    (o_pix_ready),
    .o_parallel_data(o_parallel_data),
    .o_fm_data_valid(o_fm_data_valid),
    .o_row_idx      (o_row_idx),
    .o_frame_end    (o_frame_end),
    .o_sof_err      (o_sof_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every emitted row must match the head of the expected queue.
  always @(negedge clk) begin
    if (o_fm_data_valid) begin
      pulse_cyc.push_back(cyc);
      if (o_frame_end) fe_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_row: got row idx %0d, required no emission", o_row_idx);
      end else begin
        mon_e = exp_q.pop_front();
        n_cmp += 3;
        if (o_parallel_data !== mon_e.data) begin
          n_err++;
          $display("FAIL row_data: got %h, required %h", o_parallel_data, mon_e.data);
        end
        if (o_row_idx !== mon_e.idx) begin
          n_err++;
          $display("FAIL row_idx: got %0d, required %0d", o_row_idx, mon_e.idx);
        end
        if (o_frame_end !== (mon_e.idx == 5'd25)) begin
          n_err++;
          $display("FAIL frame_end: got %b, required %b", o_frame_end, mon_e.idx == 5'd25);
        end
      end
    end else if (o_frame_end) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_end_alone: got 1, required 0");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic model_accept(input logic [7:0] d, input logic s);
    row_t r;
    if (s && (m_col != 0 || m_row != 0)) begin
      m_col = 0;
      m_row = 0;
    end
    m_data[(25 - m_col) * 8 +: 8] = d;
    if (m_col == 25) begin
      r.data = m_data;
      r.idx  = 5'(m_row);
      exp_q.push_back(r);
      row_end_edge.push_back(cyc + 1);
      m_col = 0;
      m_row = (m_row == 25) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  // One cycle: drive inputs after the falling edge, report whether the next rising edge accepts.
  task automatic step(input logic v, input logic [7:0] d, input logic s, output logic acc);
    @(negedge clk);
    en        = en_nx;
    pix_valid = v;
    pix_data  = d;
    sof       = s;
    #1;
    acc = v & o_pix_ready;
    if (acc) model_accept(d, s);
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) step(1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic clear_logs();
    pulse_cyc.delete();
    row_end_edge.delete();
    fe_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    en        = 1'b0;
    en_nx     = 1'b0;
    m_col     = 0;
    m_row     = 0;
    m_data    = '0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp += 6;
    if (o_pix_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b, required 0", o_pix_ready);
    end
    if (o_parallel_data !== '0) begin
      n_err++; $display("FAIL reset_data: got %h, required 0", o_parallel_data);
    end
    if (o_row_idx !== 5'd0) begin
      n_err++; $display("FAIL reset_idx: got %0d, required 0", o_row_idx);
    end
    if (o_fm_data_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b, required 0", o_fm_data_valid);
    end
    if (o_frame_end !== 1'b0) begin
      n_err++; $display("FAIL reset_frame_end: got %b, required 0", o_frame_end);
    end
    if (o_sof_err !== 1'b0) begin
      n_err++; $display("FAIL reset_sof_err: got %b, required 0", o_sof_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (o_pix_ready !== 1'b1) begin
      n_err++; $display("FAIL release_ready: got %b, required 1", o_pix_ready);
    end
    clear_logs();
  endtask

  task automatic test_stream();
    logic acc;
    int   nrdy = 0;
    int   bad_gap = 0;
    en_nx = 1'b1;
    for (int p = 0; p < FramePix; p++) begin
      step(1'b1, 8'(p), p == 0, acc);
      if (!acc) nrdy++;
    end
    idle(6);
    for (int i = 1; i < pulse_cyc.size(); i++) begin
      if (pulse_cyc[i] - pulse_cyc[i-1] != 26) bad_gap++;
    end
    n_cmp += 6;
    if (nrdy != 0) begin
      n_err++; $display("FAIL stream_ready_drops: got %0d, required 0", nrdy);
    end
    if (pulse_cyc.size() != 26) begin
      n_err++; $display("FAIL stream_pulses: got %0d, required 26", pulse_cyc.size());
    end
    if (pulse_cyc.size() == 0 || row_end_edge.size() == 0 ||
        pulse_cyc[0] != row_end_edge[0] + 1) begin
      n_err++;
      $display("FAIL stream_latency: got first pulse at %0d, required %0d",
               pulse_cyc.size() ? pulse_cyc[0] : -1,
               row_end_edge.size() ? row_end_edge[0] + 1 : -1);
    end
    if (bad_gap != 0) begin
      n_err++; $display("FAIL stream_spacing: got %0d bad gaps, required 0", bad_gap);
    end
    if (fe_cnt != 1) begin
      n_err++; $display("FAIL stream_frame_end: got %0d, required 1", fe_cnt);
    end
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL stream_leftover: got %0d rows pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int   p = 0;
    int   k = 0;
    int   first = 0;
    int   stalled = 0;
    int   extra = 0;
    do_reset();
    en_nx = 1'b0;
    for (int i = 0; i < 60 && stalled == 0; i++) begin
      step(1'b1, 8'(p), p == 0, acc);
      if (acc) p++;
      else stalled = 1;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(p), 1'b0, acc);
      if (acc) begin extra++; p++; end
    end
    n_cmp += 2;
    if (stalled == 0 || p - extra != 52) begin
      n_err++; $display("FAIL bp_accept_count: got %0d, required 52", p - extra);
    end
    if (extra != 0) begin
      n_err++; $display("FAIL bp_ready_low: got %0d accepts while full, required 0", extra);
    end
    en_nx = 1'b1;
    while (p < FramePix && k < 2000) begin
      k++;
      step(1'b1, 8'(p), p == 0, acc);
      if (acc) begin
        if (first == 0) first = k;
        p++;
      end
    end
    idle(6);
    n_cmp += 4;
    if (first != 2) begin
      n_err++; $display("FAIL bp_ready_return: got step %0d, required 2", first);
    end
    if (pulse_cyc.size() < 2 || pulse_cyc[1] - pulse_cyc[0] != 1) begin
      n_err++; $display("FAIL bp_consecutive: got %0d pulses not back-to-back, required adjacent",
                        pulse_cyc.size());
    end
    if (pulse_cyc.size() != 26) begin
      n_err++; $display("FAIL bp_pulses: got %0d, required 26", pulse_cyc.size());
    end
    if (fe_cnt != 1) begin
      n_err++; $display("FAIL bp_frame_end: got %0d, required 1", fe_cnt);
    end
  endtask

  task automatic test_random();
    logic acc;
    int   p = 0;
    int   k = 0;
    do_reset();
    en_nx = 1'b1;
    while (p < 3 * FramePix && k < 20000) begin
      k++;
      if ($urandom_range(0, 15) == 0) en_nx = ~en_nx;
      step(1'($urandom_range(0, 1)), 8'($urandom), (p % FramePix) == 0, acc);
      if (acc) p++;
    end
    en_nx = 1'b1;
    idle(8);
    n_cmp += 4;
    if (p != 3 * FramePix) begin
      n_err++; $display("FAIL rand_progress: got %0d pixels, required %0d", p, 3 * FramePix);
    end
    if (pulse_cyc.size() != 78) begin
      n_err++; $display("FAIL rand_pulses: got %0d, required 78", pulse_cyc.size());
    end
    if (fe_cnt != 3) begin
      n_err++; $display("FAIL rand_frame_end: got %0d, required 3", fe_cnt);
    end
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_leftover: got %0d rows pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_no_sof();
    logic acc;
    int   nrdy = 0;
    do_reset();
    en_nx = 1'b1;
    for (int p = 0; p < 2 * FramePix; p++) begin
      step(1'b1, 8'(p * 7), p == 0, acc);
      if (!acc) nrdy++;
    end
    idle(6);
    n_cmp += 4;
    if (nrdy != 0) begin
      n_err++; $display("FAIL nosof_ready_drops: got %0d, required 0", nrdy);
    end
    if (pulse_cyc.size() != 52) begin
      n_err++; $display("FAIL nosof_pulses: got %0d, required 52", pulse_cyc.size());
    end
    if (fe_cnt != 2) begin
      n_err++; $display("FAIL nosof_frame_end: got %0d, required 2", fe_cnt);
    end
    if (o_sof_err !== 1'b0) begin
      n_err++; $display("FAIL nosof_err: got %b, required 0", o_sof_err);
    end
  endtask

  task automatic test_sof_err();
    logic acc;
    do_reset();
    en_nx = 1'b1;
    for (int p = 0; p < 88; p++) step(1'b1, 8'(p), p == 0, acc);
    idle(4);
    n_cmp++;
    if (o_sof_err !== 1'b0) begin
      n_err++; $display("FAIL soferr_early: got %b, required 0", o_sof_err);
    end
    step(1'b1, 8'hA5, 1'b1, acc);
    n_cmp++;
    if (acc !== 1'b1) begin
      n_err++; $display("FAIL soferr_accept: got %b, required 1", acc);
    end
    for (int p = 0; p < 51; p++) begin
      step(1'b1, 8'(p + 200), 1'b0, acc);
      if (p == 0) begin
        n_cmp++;
        if (o_sof_err !== 1'b1) begin
          n_err++; $display("FAIL soferr_rise: got %b, required 1", o_sof_err);
        end
      end
    end
    idle(6);
    n_cmp += 3;
    if (o_sof_err !== 1'b1) begin
      n_err++; $display("FAIL soferr_sticky: got %b, required 1", o_sof_err);
    end
    if (pulse_cyc.size() != 5) begin
      n_err++; $display("FAIL soferr_pulses: got %0d, required 5", pulse_cyc.size());
    end
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL soferr_leftover: got %0d rows pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int   nrdy = 0;
    en_nx = 1'b0;
    for (int p = 0; p < 31; p++) step(1'b1, 8'(p + 100), 1'b0, acc);
    @(negedge clk);
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    m_col     = 0;
    m_row     = 0;
    m_data    = '0;
    exp_q.delete();
    @(negedge clk);
    #1;
    n_cmp += 4;
    if (o_pix_ready !== 1'b0) begin
      n_err++; $display("FAIL rmid_ready: got %b, required 0", o_pix_ready);
    end
    if (o_parallel_data !== '0 || o_row_idx !== 5'd0) begin
      n_err++; $display("FAIL rmid_data: got %h/%0d, required 0/0", o_parallel_data, o_row_idx);
    end
    if (o_fm_data_valid !== 1'b0 || o_frame_end !== 1'b0) begin
      n_err++; $display("FAIL rmid_pulse: got %b%b, required 00", o_fm_data_valid, o_frame_end);
    end
    if (o_sof_err !== 1'b0) begin
      n_err++; $display("FAIL rmid_sof_err: got %b, required 0", o_sof_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    en_nx = 1'b1;
    for (int p = 0; p < FramePix; p++) begin
      step(1'b1, 8'(p * 3 + 1), p == 0, acc);
      if (!acc) nrdy++;
    end
    idle(6);
    n_cmp += 3;
    if (nrdy != 0) begin
      n_err++; $display("FAIL rmid_ready_drops: got %0d, required 0", nrdy);
    end
    if (pulse_cyc.size() != 26) begin
      n_err++; $display("FAIL rmid_pulses: got %0d, required 26", pulse_cyc.size());
    end
    if (fe_cnt != 1) begin
      n_err++; $display("FAIL rmid_frame_end: got %0d, required 1", fe_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_no_sof();
    test_sof_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fm_row_packer.md
# fm_row_packer

Feature-map row packer for the MNIST CNN accelerator. It accepts a byte-serial pixel stream (one 8-bit pixel per transfer, valid/ready handshake) and assembles 26-pixel rows into the 208-bit row word consumed by conv layer 1 (`parallel_data` / `fm_data_valid`). It double-buffers rows so that input can run at one pixel per cycle while the accelerator is still loading weights. It tags each emitted row with its row index and marks the end of each 26×26 frame.

## Interface
Parameters:
- `PIX_W`, 8, pixel width in bits
- `ROW_PIX`, 26, pixels per row and rows per frame

Ports:
- `i_clk`  in  1  single clock; all logic on rising edge
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_en`  in  1  output enable (DMA finish and weights loaded); gates row emission only
- `i_pix_data`  in  8  pixel byte
- `i_pix_valid`  in  1  pixel present
- `i_sof`  in  1  qualifies the current pixel as frame pixel (row 0, col 0)
- `o_pix_ready`  out  1  packer can accept a pixel this cycle
- `o_parallel_data`  out  208  packed row; col 0 in [207:200], col 25 in [7:0]
- `o_fm_data_valid`  out  1  one-cycle pulse per emitted row
- `o_row_idx`  out  5  row index (0..25) of the emitted row
- `o_frame_end`  out  1  high with `o_fm_data_valid` when `o_row_idx`==25
- `o_sof_err`  out  1  sticky: `i_sof` seen mid-frame

## Operation
- Two row buffers B0/B1, each holding 208 data bits, a 5-bit row tag, and a full flag.
- Write side: `wr_sel`, column counter `col` (0..25), write-row counter `wr_row` (0..25).
- Read side: `rd_sel`.
- Accept condition: `i_pix_valid & o_pix_ready`.
- `o_pix_ready` = `i_rst_n & ~full[wr_sel]`. It is combinational and does not depend on `i_pix_valid`.
- On an accepted pixel:
  - The byte is written into B[`wr_sel`] at column `col`, and `col` increments.
  - At `col`==25: set `full[wr_sel]`, set tag = `wr_row`, toggle `wr_sel`, `col`←0, `wr_row`←(`wr_row`==25 ? 0 : `wr_row`+1).
- SOF handling, on an accepted pixel with `i_sof`=1:
  - Normal case (`col`==0 and `wr_row`==0): no special action.
  - Mid-frame case (otherwise):
    - Discard the partial row: `col` is treated as 0 and `wr_row` as 0, so the pixel lands in col 0 of a row tagged 0.
    - Set `o_sof_err`. It clears only on reset.
    - Full buffers already queued are kept and emitted with their original tags.
- A frame start without `i_sof` is not an error; the counters simply continue.
- Read side: when `i_en` & `full[rd_sel]`:
  - Load B[`rd_sel`] into `o_parallel_data` and its tag into `o_row_idx`.
  - Pulse `o_fm_data_valid`; pulse `o_frame_end` if the tag is 25.
  - Clear `full[rd_sel]` and toggle `rd_sel`.
- Emission rate: at most one row per cycle. Rows are emitted strictly in write order.
- Write completion and read of the other buffer may occur in the same cycle.
- A buffer that completes in cycle t is not readable before cycle t+1.
- `i_en` low:
  - No emission; the write side continues until both buffers are full (52 pixels), then `o_pix_ready` drops.
  - Deasserting `i_en` mid-frame does not disturb any state.
- Between pulses, `o_parallel_data` and `o_row_idx` hold the last emitted row. `o_fm_data_valid` and `o_frame_end` are 0.

## Timing
- Reset (`i_rst_n` low at a rising edge):
  - Clears full flags, `wr_sel`, `rd_sel`, `col`, `wr_row`, and buffer tags.
  - Clears `o_parallel_data`, `o_row_idx`, `o_fm_data_valid`, `o_frame_end`, `o_sof_err`.
  - `o_pix_ready` is 0 while `i_rst_n` is low and 1 in the first cycle after release.
  - Reset mid-row or mid-frame discards all buffered data; no row is emitted for it.
- Latency: last pixel of a row accepted in cycle t → `full` is high in t+1 → `o_fm_data_valid` is high in t+2 (given `i_en`=1 and the other buffer is not ahead in the queue).
- Throughput: one pixel per cycle sustained with `i_en`=1. `o_pix_ready` never drops, and one row is emitted every 26 cycles.
- Backpressure: pixels are not lost or duplicated. A pixel is consumed only in a cycle where both valid and ready are high.

## Test plan
- Reset release, `i_en`=1, stream pixels 0..675 back-to-back with `i_sof` on pixel 0:
  - 26 valid pulses, 26 cycles apart; the first pulse appears 2 cycles after pixel 25 is accepted.
  - Row r has [207:200]=26r mod 256 and `o_row_idx`=r.
  - `o_frame_end` occurs only on row 25; `o_pix_ready` stays 1.
- `i_en`=0, stream continuously:
  - `o_pix_ready` falls after exactly 52 accepted pixels.
  - Raising `i_en` emits rows 0 and 1 on consecutive cycles, after which ready returns.
- Random `i_pix_valid` (50%) and random `i_en` toggling over 3 frames: emitted rows match a scoreboard bit-exactly and in order; no lost or duplicated pixels.
- `i_sof` asserted at row 3, col 10: `o_sof_err` rises and stays set; rows 0–2 are emitted; partial row 3 is never emitted; the next rows are tagged 0,1,….
- Second frame without `i_sof`: tags wrap 25→0, `o_frame_end` pulses twice in total, `o_sof_err` stays 0.
- Reset asserted mid-row with one full buffer pending: all outputs are 0 the next cycle, the pending row is never emitted, and a fresh frame then passes correctly.
